multicycle_control: RTL and testbench

Multi-cycle main control unit replacing the single-cycle opcode decoder: a Moore FSM that sequences each instruction through fetch, decode, execute, memory and writeback cycles and drives the datapath's per-cycle control lines. It supports R-format, lw, sw, beq, nandi, baln, bgezal and jsp. Memory accesses use a ready handshake with a parametrised timeout, and undefined opcodes trap to a sticky fault state.

---
 rtl/multicycle_control_if.sv | 40 ++++
 rtl/multicycle_control.sv | 189 ++++++++++++++++++
 tb/tb_multicycle_control.sv | 287 ++++++++++++++++++++++++++++
 3 files changed

// File: rtl/multicycle_control_if.sv
// Control-unit to datapath bundle: instruction/status inputs and per-cycle control lines.
// master = control unit, slave = datapath side.
interface multicycle_control_if;
    logic [5:0] opcode;
    logic       mem_ready;
    logic       n_flag;
    logic       rs_sign;

    logic       pcwrite;
    logic       pcwritecond;
    logic       iord;
    logic       irwrite;
    logic       memread;
    logic       memwrite;
    logic       memtoreg;
    logic       regdest;
    logic       regwrite;
    logic       alusrca;
    logic       link;
    logic [1:0] alusrcb;
    logic [1:0] aluop;
    logic [1:0] pcsource;
    logic       instr_done;
    logic       fault;
    logic [3:0] state;

    modport master (
        input  opcode, mem_ready, n_flag, rs_sign,
        output pcwrite, pcwritecond, iord, irwrite, memread, memwrite, memtoreg,
               regdest, regwrite, alusrca, link, alusrcb, aluop, pcsource,
               instr_done, fault, state
    );

    modport slave (
        output opcode, mem_ready, n_flag, rs_sign,
        input  pcwrite, pcwritecond, iord, irwrite, memread, memwrite, memtoreg,
               regdest, regwrite, alusrca, link, alusrcb, aluop, pcsource,
               instr_done, fault, state
    );
endinterface

// File: rtl/multicycle_control.sv
// Moore multi-cycle main control: fetch/decode/execute/memory/writeback sequencing.
// Memory states wait on mem_ready (bounded by TIMEOUT); illegal opcodes or timeouts park in FAULT.
module multicycle_control #(
    parameter bit MEM_HANDSHAKE = 1'b1,
    parameter int TIMEOUT       = 16,
    parameter int CNT_W         = 5
) (
    input  logic               clk,
    input  logic               reset,
    multicycle_control_if.master bus
);
    localparam logic [5:0] OP_R      = 6'b000000;
    localparam logic [5:0] OP_LW     = 6'b100011;
    localparam logic [5:0] OP_SW     = 6'b101011;
    localparam logic [5:0] OP_BEQ    = 6'b000100;
    localparam logic [5:0] OP_NANDI  = 6'b010000;
    localparam logic [5:0] OP_BALN   = 6'b011011;
    localparam logic [5:0] OP_BGEZAL = 6'b000001;
    localparam logic [5:0] OP_JSP    = 6'b010010;

    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT - 1);

    typedef enum logic [3:0] {
        S_FETCH  = 4'd0,
        S_DECODE = 4'd1,
        S_EXEC_R = 4'd2,
        S_WB_R   = 4'd3,
        S_ADDR   = 4'd4,
        S_MEM_RD = 4'd5,
        S_WB_MEM = 4'd6,
        S_MEM_WR = 4'd7,
        S_EXEC_I = 4'd8,
        S_WB_I   = 4'd9,
        S_BEQ    = 4'd10,
        S_BRLINK = 4'd11,
        S_JSP_RD = 4'd12,
        S_FAULT  = 4'd13
    } state_t;

    state_t           cur;
    logic [CNT_W-1:0] wait_cnt;
    logic [5:0]       op_q;
    logic             in_mem;
    logic             acc_done;
    logic             timed_out;

    assign in_mem    = (cur == S_FETCH) || (cur == S_MEM_RD) ||
                       (cur == S_MEM_WR) || (cur == S_JSP_RD);
    assign acc_done  = MEM_HANDSHAKE ? bus.mem_ready : 1'b1;
    // Completion in the same cycle as the last allowed wait beats the timeout.
    assign timed_out = (TIMEOUT != 0) && in_mem && !acc_done && (wait_cnt == CNT_LAST);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            cur      <= S_FETCH;
            wait_cnt <= '0;
            op_q     <= '0;
        end else begin
            // Any state change clears the counter, so it restarts on entry to a memory state.
            wait_cnt <= '0;
            if (in_mem && !acc_done && !timed_out) begin
                wait_cnt <= wait_cnt + 1'b1;
            end
            case (cur)
                S_FETCH: begin
                    if (timed_out)     cur <= S_FAULT;
                    else if (acc_done) cur <= S_DECODE;
                end
                S_DECODE: begin
                    op_q <= bus.opcode;
                    case (bus.opcode)
                        OP_R:               cur <= S_EXEC_R;
                        OP_LW, OP_SW:       cur <= S_ADDR;
                        OP_NANDI:           cur <= S_EXEC_I;
                        OP_BEQ:             cur <= S_BEQ;
                        OP_BALN, OP_BGEZAL: cur <= S_BRLINK;
                        OP_JSP:             cur <= S_JSP_RD;
                        default:            cur <= S_FAULT;
                    endcase
                end
                S_EXEC_R: cur <= S_WB_R;
                S_ADDR:   cur <= (op_q == OP_SW) ? S_MEM_WR : S_MEM_RD;
                S_MEM_RD: begin
                    if (timed_out)     cur <= S_FAULT;
                    else if (acc_done) cur <= S_WB_MEM;
                end
                S_MEM_WR, S_JSP_RD: begin
                    if (timed_out)     cur <= S_FAULT;
                    else if (acc_done) cur <= S_FETCH;
                end
                S_EXEC_I: cur <= S_WB_I;
                S_WB_R, S_WB_MEM, S_WB_I, S_BEQ, S_BRLINK: cur <= S_FETCH;
                S_FAULT:  cur <= S_FAULT;
                default:  cur <= S_FAULT;
            endcase
        end
    end

    always_comb begin
        bus.pcwrite     = 1'b0;
        bus.pcwritecond = 1'b0;
        bus.iord        = 1'b0;
        bus.irwrite     = 1'b0;
        bus.memread     = 1'b0;
        bus.memwrite    = 1'b0;
        bus.memtoreg    = 1'b0;
        bus.regdest     = 1'b0;
        bus.regwrite    = 1'b0;
        bus.alusrca     = 1'b0;
        bus.link        = 1'b0;
        bus.alusrcb     = 2'b00;
        bus.aluop       = 2'b00;
        bus.pcsource    = 2'b00;
        bus.instr_done  = 1'b0;
        bus.fault       = 1'b0;
        case (cur)
            S_FETCH: begin
                bus.memread = 1'b1;
                bus.alusrcb = 2'b01;
                bus.irwrite = acc_done;
                bus.pcwrite = acc_done;
            end
            S_DECODE: bus.alusrcb = 2'b11;
            S_EXEC_R: begin
                bus.alusrca = 1'b1;
                bus.aluop   = 2'b10;
            end
            S_WB_R: begin
                bus.regdest    = 1'b1;
                bus.regwrite   = 1'b1;
                bus.instr_done = 1'b1;
            end
            S_ADDR: begin
                bus.alusrca = 1'b1;
                bus.alusrcb = 2'b10;
            end
            S_MEM_RD: begin
                bus.memread = 1'b1;
                bus.iord    = 1'b1;
            end
            S_WB_MEM: begin
                bus.regwrite   = 1'b1;
                bus.memtoreg   = 1'b1;
                bus.instr_done = 1'b1;
            end
            S_MEM_WR: begin
                bus.memwrite   = 1'b1;
                bus.iord       = 1'b1;
                bus.instr_done = acc_done;
            end
            S_EXEC_I: begin
                bus.alusrca = 1'b1;
                bus.alusrcb = 2'b10;
                bus.aluop   = 2'b11;
            end
            S_WB_I: begin
                bus.regwrite   = 1'b1;
                bus.instr_done = 1'b1;
            end
            S_BEQ: begin
                bus.alusrca     = 1'b1;
                bus.aluop       = 2'b01;
                bus.pcwritecond = 1'b1;
                bus.pcsource    = 2'b01;
                bus.instr_done  = 1'b1;
            end
            S_BRLINK: begin
                bus.link       = 1'b1;
                bus.regwrite   = 1'b1;
                bus.pcsource   = 2'b01;
                bus.instr_done = 1'b1;
                bus.pcwrite    = (op_q == OP_BALN) ? bus.n_flag : ~bus.rs_sign;
            end
            S_JSP_RD: begin
                bus.memread    = 1'b1;
                bus.iord       = 1'b1;
                bus.alusrca    = 1'b1;
                bus.alusrcb    = 2'b10;
                bus.pcwrite    = acc_done;
                bus.pcsource   = acc_done ? 2'b10 : 2'b00;
                bus.instr_done = acc_done;
            end
            S_FAULT: bus.fault = 1'b1;
            default: bus.fault = 1'b1;
        endcase
    end

    assign bus.state = cur;
endmodule

// File: tb/tb_multicycle_control.sv
// Bench for multicycle_control: vector table, phase-level reference model with random waits,
// plus hand sequences for timeout, illegal opcode, no-handshake mode and async reset.
module tb_multicycle_control;
    localparam logic [5:0] OP_R      = 6'b000000;
    localparam logic [5:0] OP_LW     = 6'b100011;
    localparam logic [5:0] OP_SW     = 6'b101011;
    localparam logic [5:0] OP_BEQ    = 6'b000100;
    localparam logic [5:0] OP_NANDI  = 6'b010000;
    localparam logic [5:0] OP_BALN   = 6'b011011;
    localparam logic [5:0] OP_BGEZAL = 6'b000001;
    localparam logic [5:0] OP_JSP    = 6'b010010;

    typedef struct packed {
        logic pcwrite, pcwritecond, iord, irwrite, memread, memwrite, memtoreg,
              regdest, regwrite, alusrca, link;
        logic [1:0] alusrcb, aluop, pcsource;
        logic instr_done, fault;
    } ctl_t;

    typedef enum {P_FETCH, P_DEC, P_EXR, P_WBR, P_ADDR, P_MRD, P_WBM, P_MWR,
                  P_EXI, P_WBI, P_BEQ, P_BRL, P_JSP} phase_e;

    typedef struct {
        logic [5:0] op;
        logic       nf;
        logic       rs;
        int         low_from;
        int         low_n;
        int         cycles;
        ctl_t       last;
    } vec_t;

    logic clk = 1'b0;
    logic rst_a, rst_b, rst_c;
    int   checks = 0;
    int   errors = 0;
    phase_e plan[$];
    vec_t   tbl[$];
    logic [5:0] legal [8] = '{OP_R, OP_LW, OP_SW, OP_BEQ, OP_NANDI, OP_BALN, OP_BGEZAL, OP_JSP};

    always #5 clk = ~clk;

    multicycle_control_if bus_a();
    multicycle_control_if bus_b();
    multicycle_control_if bus_c();

    multicycle_control #(.MEM_HANDSHAKE(1'b1), .TIMEOUT(16), .CNT_W(5))
        dut_a (.clk(clk), .reset(rst_a), .bus(bus_a.master));
    multicycle_control #(.MEM_HANDSHAKE(1'b1), .TIMEOUT(4), .CNT_W(3))
        dut_b (.clk(clk), .reset(rst_b), .bus(bus_b.master));
    multicycle_control #(.MEM_HANDSHAKE(1'b0), .TIMEOUT(16), .CNT_W(5))
        dut_c (.clk(clk), .reset(rst_c), .bus(bus_c.master));

    ctl_t va, vb, vc;
    assign va = {bus_a.pcwrite, bus_a.pcwritecond, bus_a.iord, bus_a.irwrite, bus_a.memread,
                 bus_a.memwrite, bus_a.memtoreg, bus_a.regdest, bus_a.regwrite, bus_a.alusrca,
                 bus_a.link, bus_a.alusrcb, bus_a.aluop, bus_a.pcsource, bus_a.instr_done, bus_a.fault};
    assign vb = {bus_b.pcwrite, bus_b.pcwritecond, bus_b.iord, bus_b.irwrite, bus_b.memread,
                 bus_b.memwrite, bus_b.memtoreg, bus_b.regdest, bus_b.regwrite, bus_b.alusrca,
                 bus_b.link, bus_b.alusrcb, bus_b.aluop, bus_b.pcsource, bus_b.instr_done, bus_b.fault};
    assign vc = {bus_c.pcwrite, bus_c.pcwritecond, bus_c.iord, bus_c.irwrite, bus_c.memread,
                 bus_c.memwrite, bus_c.memtoreg, bus_c.regdest, bus_c.regwrite, bus_c.alusrca,
                 bus_c.link, bus_c.alusrcb, bus_c.aluop, bus_c.pcsource, bus_c.instr_done, bus_c.fault};

    // bits: pcwrite pcwritecond iord irwrite memread memwrite memtoreg regdest regwrite alusrca link
    function automatic ctl_t mk(input logic [10:0] b, input logic [1:0] srcb, input logic [1:0] op,
                                input logic [1:0] pcs, input logic done, input logic flt);
        mk = {b, srcb, op, pcs, done, flt};
    endfunction

    function automatic ctl_t expect_ctl(input phase_e p, input logic rdy, input logic brc);
        case (p)
            P_FETCH: expect_ctl = mk({rdy, 2'b00, rdy, 1'b1, 6'b000000}, 2'b01, 2'b00, 2'b00, 1'b0, 1'b0);
            P_DEC:   expect_ctl = mk(11'b0, 2'b11, 2'b00, 2'b00, 1'b0, 1'b0);
            P_EXR:   expect_ctl = mk(11'b00000000010, 2'b00, 2'b10, 2'b00, 1'b0, 1'b0);
            P_WBR:   expect_ctl = mk(11'b00000001100, 2'b00, 2'b00, 2'b00, 1'b1, 1'b0);
            P_ADDR:  expect_ctl = mk(11'b00000000010, 2'b10, 2'b00, 2'b00, 1'b0, 1'b0);
            P_MRD:   expect_ctl = mk(11'b00101000000, 2'b00, 2'b00, 2'b00, 1'b0, 1'b0);
            P_WBM:   expect_ctl = mk(11'b00000010100, 2'b00, 2'b00, 2'b00, 1'b1, 1'b0);
            P_MWR:   expect_ctl = mk(11'b00100100000, 2'b00, 2'b00, 2'b00, rdy, 1'b0);
            P_EXI:   expect_ctl = mk(11'b00000000010, 2'b10, 2'b11, 2'b00, 1'b0, 1'b0);
            P_WBI:   expect_ctl = mk(11'b00000000100, 2'b00, 2'b00, 2'b00, 1'b1, 1'b0);
            P_BEQ:   expect_ctl = mk(11'b01000000010, 2'b00, 2'b01, 2'b01, 1'b1, 1'b0);
            P_BRL:   expect_ctl = mk({brc, 10'b0000000101}, 2'b00, 2'b00, 2'b01, 1'b1, 1'b0);
            P_JSP:   expect_ctl = mk({rdy, 1'b0, 1'b1, 1'b0, 1'b1, 4'b0000, 1'b1, 1'b0}, 2'b10,
                                     2'b00, rdy ? 2'b10 : 2'b00, rdy, 1'b0);
            default: expect_ctl = '0;
        endcase
    endfunction

    function automatic ctl_t fault_ctl();
        fault_ctl = mk(11'b0, 2'b00, 2'b00, 2'b00, 1'b0, 1'b1);
    endfunction

    function automatic bit is_mem(input phase_e p);
        is_mem = (p == P_FETCH) || (p == P_MRD) || (p == P_MWR) || (p == P_JSP);
    endfunction

    function automatic void build(input logic [5:0] op);
        plan.delete();
        plan.push_back(P_FETCH);
        plan.push_back(P_DEC);
        case (op)
            OP_R:               begin plan.push_back(P_EXR); plan.push_back(P_WBR); end
            OP_LW:              begin plan.push_back(P_ADDR); plan.push_back(P_MRD); plan.push_back(P_WBM); end
            OP_SW:              begin plan.push_back(P_ADDR); plan.push_back(P_MWR); end
            OP_NANDI:           begin plan.push_back(P_EXI); plan.push_back(P_WBI); end
            OP_BEQ:             plan.push_back(P_BEQ);
            OP_BALN, OP_BGEZAL: plan.push_back(P_BRL);
            OP_JSP:             plan.push_back(P_JSP);
            default:            ;
        endcase
    endfunction

    task automatic chk_ctl(input string nm, input ctl_t act, input ctl_t exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %05h expected %05h", nm, act, exp);
        end
    endtask

    task automatic chk_int(input string nm, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", nm, act, exp);
        end
    endtask

    task automatic reset_a();
        rst_a = 1'b1; #1; rst_a = 1'b0;
    endtask

    // Runs one instruction on dut_a from the start of its FETCH cycle, checking every cycle.
    task automatic run_model(input logic [5:0] op);
        int w;
        logic rdy, brc;
        build(op);
        bus_a.opcode = op;
        foreach (plan[i]) begin
            w = is_mem(plan[i]) ? $urandom_range(0, 3) : 0;
            for (int k = 0; k <= w; k++) begin
                rdy = is_mem(plan[i]) ? (k == w) : 1'($urandom);
                bus_a.mem_ready = rdy;
                bus_a.n_flag    = 1'($urandom);
                bus_a.rs_sign   = 1'($urandom);
                if (plan[i] == P_BRL) bus_a.opcode = (op == OP_BALN) ? OP_BGEZAL : OP_BALN;
                brc = (op == OP_BALN) ? bus_a.n_flag : ~bus_a.rs_sign;
                @(negedge clk);
                chk_ctl($sformatf("model op=%b %s", op, plan[i].name()), va, expect_ctl(plan[i], rdy, brc));
                @(posedge clk); #1;
            end
        end
    endtask

    initial begin
        int   cyc;
        logic done;
        ctl_t last;
        logic [5:0] ill;

        rst_a = 1'b1; rst_b = 1'b1; rst_c = 1'b1;
        bus_a.opcode = OP_R; bus_a.mem_ready = 1'b0; bus_a.n_flag = 1'b0; bus_a.rs_sign = 1'b0;
        bus_b.opcode = OP_R; bus_b.mem_ready = 1'b0; bus_b.n_flag = 1'b0; bus_b.rs_sign = 1'b0;
        bus_c.opcode = OP_LW; bus_c.mem_ready = 1'b0; bus_c.n_flag = 1'b0; bus_c.rs_sign = 1'b0;
        @(posedge clk); #1;
        chk_ctl("reset a fetch wait", va, expect_ctl(P_FETCH, 1'b0, 1'b0));
        chk_ctl("reset b fetch wait", vb, expect_ctl(P_FETCH, 1'b0, 1'b0));
        chk_ctl("reset c fetch nohs", vc, expect_ctl(P_FETCH, 1'b1, 1'b0));
        bus_a.mem_ready = 1'b1; #1;
        chk_ctl("reset a fetch ready", va, expect_ctl(P_FETCH, 1'b1, 1'b0));
        #1; rst_a = 1'b0; rst_b = 1'b0; rst_c = 1'b0;

        // op, n_flag, rs_sign, ready-low window start/length (cycle numbers), cycles, last-cycle controls
        tbl.push_back('{OP_R,      1'b0, 1'b0, 2, 2, 4, mk(11'b00000001100, 2'b00, 2'b00, 2'b00, 1'b1, 1'b0)});
        tbl.push_back('{OP_LW,     1'b0, 1'b0, 0, 0, 5, mk(11'b00000010100, 2'b00, 2'b00, 2'b00, 1'b1, 1'b0)});
        tbl.push_back('{OP_LW,     1'b0, 1'b0, 4, 2, 7, mk(11'b00000010100, 2'b00, 2'b00, 2'b00, 1'b1, 1'b0)});
        tbl.push_back('{OP_SW,     1'b0, 1'b0, 0, 0, 4, mk(11'b00100100000, 2'b00, 2'b00, 2'b00, 1'b1, 1'b0)});
        tbl.push_back('{OP_SW,     1'b0, 1'b0, 4, 3, 7, mk(11'b00100100000, 2'b00, 2'b00, 2'b00, 1'b1, 1'b0)});
        tbl.push_back('{OP_NANDI,  1'b0, 1'b0, 0, 0, 4, mk(11'b00000000100, 2'b00, 2'b00, 2'b00, 1'b1, 1'b0)});
        tbl.push_back('{OP_BEQ,    1'b0, 1'b0, 0, 0, 3, mk(11'b01000000010, 2'b00, 2'b01, 2'b01, 1'b1, 1'b0)});
        tbl.push_back('{OP_BALN,   1'b1, 1'b1, 0, 0, 3, mk(11'b10000000101, 2'b00, 2'b00, 2'b01, 1'b1, 1'b0)});
        tbl.push_back('{OP_BALN,   1'b0, 1'b0, 0, 0, 3, mk(11'b00000000101, 2'b00, 2'b00, 2'b01, 1'b1, 1'b0)});
        tbl.push_back('{OP_BGEZAL, 1'b1, 1'b0, 0, 0, 3, mk(11'b10000000101, 2'b00, 2'b00, 2'b01, 1'b1, 1'b0)});
        tbl.push_back('{OP_BGEZAL, 1'b0, 1'b1, 0, 0, 3, mk(11'b00000000101, 2'b00, 2'b00, 2'b01, 1'b1, 1'b0)});
        tbl.push_back('{OP_JSP,    1'b0, 1'b0, 0, 0, 3, mk(11'b10101000010, 2'b10, 2'b00, 2'b10, 1'b1, 1'b0)});
        tbl.push_back('{OP_JSP,    1'b0, 1'b0, 3, 2, 5, mk(11'b10101000010, 2'b10, 2'b00, 2'b10, 1'b1, 1'b0)});

        foreach (tbl[r]) begin
            reset_a();
            bus_a.opcode  = tbl[r].op;
            bus_a.n_flag  = tbl[r].nf;
            bus_a.rs_sign = tbl[r].rs;
            cyc = 0; done = 1'b0; last = '0;
            while (!done && cyc < 20) begin
                cyc++;
                bus_a.mem_ready = !(cyc >= tbl[r].low_from && cyc < tbl[r].low_from + tbl[r].low_n);
                @(negedge clk);
                last = va;
                done = va.instr_done;
                @(posedge clk); #1;
            end
            chk_int($sformatf("table %0d op=%b cycles", r, tbl[r].op), cyc, tbl[r].cycles);
            chk_ctl($sformatf("table %0d op=%b last", r, tbl[r].op), last, tbl[r].last);
        end

        reset_a();
        repeat (150) run_model(legal[$urandom_range(0, 7)]);

        // Illegal opcodes: DECODE goes to a sticky FAULT with every other output low.
        for (int n = 0; n < 4; n++) begin
            ill = 6'b111111;
            if (n > 0) begin
                ill = 6'($urandom);
                while (ill inside {OP_R, OP_LW, OP_SW, OP_BEQ, OP_NANDI, OP_BALN, OP_BGEZAL, OP_JSP})
                    ill = 6'($urandom);
            end
            reset_a();
            bus_a.opcode = ill; bus_a.mem_ready = 1'b1;
            @(negedge clk); chk_ctl($sformatf("illegal %b fetch", ill), va, expect_ctl(P_FETCH, 1'b1, 1'b0));
            @(posedge clk); #1;
            @(negedge clk); chk_ctl($sformatf("illegal %b decode", ill), va, expect_ctl(P_DEC, 1'b0, 1'b0));
            @(posedge clk); #1;
            for (int k = 0; k < 4; k++) begin
                bus_a.mem_ready = 1'($urandom); bus_a.n_flag = 1'($urandom); bus_a.opcode = OP_LW;
                @(negedge clk); chk_ctl($sformatf("illegal %b fault %0d", ill, k), va, fault_ctl());
                @(posedge clk); #1;
            end
        end

        // R-format then nandi, with reset asserted in the middle of EXEC_I.
        reset_a();
        run_model(OP_R);
        bus_a.opcode = OP_NANDI; bus_a.mem_ready = 1'b1;
        @(negedge clk); chk_ctl("nandi fetch", va, expect_ctl(P_FETCH, 1'b1, 1'b0));
        @(posedge clk); #1;
        @(negedge clk); chk_ctl("nandi decode", va, expect_ctl(P_DEC, 1'b0, 1'b0));
        @(posedge clk); #1;
        bus_a.mem_ready = 1'b0;
        @(negedge clk); chk_ctl("nandi exec_i", va, expect_ctl(P_EXI, 1'b0, 1'b0));
        #1; rst_a = 1'b1; #1;
        chk_ctl("async reset in exec_i", va, expect_ctl(P_FETCH, 1'b0, 1'b0));
        #1; rst_a = 1'b0;
        @(posedge clk); #1;

        // TIMEOUT=4: four waiting FETCH cycles, then sticky FAULT.
        rst_b = 1'b1; #1; rst_b = 1'b0;
        bus_b.mem_ready = 1'b0;
        for (int k = 1; k <= 4; k++) begin
            @(negedge clk); chk_ctl($sformatf("timeout fetch wait %0d", k), vb, expect_ctl(P_FETCH, 1'b0, 1'b0));
            @(posedge clk); #1;
        end
        for (int k = 0; k < 4; k++) begin
            @(negedge clk); chk_ctl($sformatf("timeout fault %0d", k), vb, fault_ctl());
            @(posedge clk); #1;
            bus_b.mem_ready = 1'($urandom);
        end
        bus_b.mem_ready = 1'b0; rst_b = 1'b1; #1;
        chk_ctl("timeout reset clears fault", vb, expect_ctl(P_FETCH, 1'b0, 1'b0));
        rst_b = 1'b0;
        // Ready arriving on the last allowed wait cycle completes instead of faulting.
        for (int k = 1; k <= 4; k++) begin
            bus_b.mem_ready = (k == 4);
            @(negedge clk); chk_ctl($sformatf("completion wins %0d", k), vb, expect_ctl(P_FETCH, k == 4, 1'b0));
            @(posedge clk); #1;
        end
        @(negedge clk); chk_ctl("completion wins decode", vb, expect_ctl(P_DEC, 1'b0, 1'b0));
        @(posedge clk); #1;

        // No handshake: mem_ready stuck low, memory states still finish in one cycle.
        rst_c = 1'b1; #1; rst_c = 1'b0;
        bus_c.mem_ready = 1'b0;
        for (int n = 0; n < 2; n++) begin
            build(n == 0 ? OP_LW : OP_SW);
            bus_c.opcode = (n == 0) ? OP_LW : OP_SW;
            foreach (plan[i]) begin
                @(negedge clk);
                chk_ctl($sformatf("nohs %0d %s", n, plan[i].name()), vc, expect_ctl(plan[i], 1'b1, 1'b0));
                @(posedge clk); #1;
            end
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
